// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// FSM state type and op-decoding helpers.
package muldiv_pkg;

    // op_i encodings
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Bit 0 marks the unsigned variants, bit 1 the divide variants
    localparam int unsigned OP_UNSIGNED_BIT = 0;
    localparam int unsigned OP_DIV_BIT      = 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StDone = 2'd3
    } muldiv_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[OP_UNSIGNED_BIT];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[OP_DIV_BIT];
    endfunction

endpackage

// File: rtl/muldiv_abs_neg.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore the sign of products, quotients and remainders.
module muldiv_abs_neg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    // Pass through, or invert-and-increment when negate is set
    always_comb begin
        result = value;
        if (negate) begin
            result = ~value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide engine for the EX stage (mult, multu, div, divu).
// Shift-add multiply and restoring divide, one bit per cycle, operating on
// magnitudes with a sign fix-up in DONE.
// Optional macro EX_MULDIV_EARLY_OUT_EN: multiply finishes as soon as the
// remaining multiplier bits are all zero.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic [WIDTH-1:0] result_lo_o,
    output logic             div_by_zero_o
);

    muldiv_state_e state_q, state_d;

    // acc holds {hi, lo}: for multiply the partial product shifting in over
    // the multiplier, for divide the partial remainder over the dividend/quotient.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;

    // Operand magnitudes for signed ops
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign signed_op = op_is_signed(op_i);
    assign a_neg     = signed_op & opdata1_i[WIDTH-1];
    assign b_neg     = signed_op & opdata2_i[WIDTH-1];

    muldiv_abs_neg #(
        .WIDTH (WIDTH)
    ) u_abs_a (
        .value  (opdata1_i),
        .negate (a_neg),
        .result (a_mag)
    );

    muldiv_abs_neg #(
        .WIDTH (WIDTH)
    ) u_abs_b (
        .value  (opdata2_i),
        .negate (b_neg),
        .result (b_mag)
    );

    // One shift-add multiply step and one restoring divide step
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;
    logic [CNT_W-1:0]   cnt_dec;

    // Datapath for a single iteration of either algorithm
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        // Partial remainder is always below the divisor, so a clear MSB means no borrow
        div_ok    = ~div_trial[WIDTH];
        if (div_ok) begin
            div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_dec = cnt_q - CNT_W'(1);
    end

`ifdef EX_MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0]   rem_mask;
    logic               mul_rem_zero;
    logic [2*WIDTH-1:0] mul_aligned;

    // After this step cnt_dec multiplier bits are still unshifted; if they are
    // all zero the remaining steps are pure shifts and can be done at once.
    always_comb begin
        rem_mask     = (WIDTH'(1) << cnt_dec) - WIDTH'(1);
        mul_rem_zero = (mul_next[WIDTH-1:0] & rem_mask) == '0;
        mul_aligned  = mul_next >> cnt_dec;
    end
`endif

    // Sign fix-up of the finished magnitudes
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    muldiv_abs_neg #(
        .WIDTH (2 * WIDTH)
    ) u_fix_prod (
        .value  (acc_q),
        .negate (neg_lo_q),
        .result (prod_fix)
    );

    muldiv_abs_neg #(
        .WIDTH (WIDTH)
    ) u_fix_quo (
        .value  (acc_q[WIDTH-1:0]),
        .negate (neg_lo_q),
        .result (quo_fix)
    );

    muldiv_abs_neg #(
        .WIDTH (WIDTH)
    ) u_fix_rem (
        .value  (acc_q[2*WIDTH-1:WIDTH]),
        .negate (neg_hi_q),
        .result (rem_fix)
    );

    // Select the fixed-up result pair; divide-by-zero carries its raw values
    // through with both sign flags clear.
    always_comb begin
        fix_hi = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        fix_lo = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dbz_d    = dbz_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && !annul_i) begin
                    is_div_d = op_is_div(op_i);
                    dbz_d    = 1'b0;
                    cnt_d    = CNT_W'(WIDTH);
                    if (op_is_div(op_i)) begin
                        opnd_d = b_mag;
                        if (opdata2_i == '0) begin
                            acc_d    = {opdata1_i, {WIDTH{1'b1}}};
                            neg_lo_d = 1'b0;
                            neg_hi_d = 1'b0;
                            dbz_d    = 1'b1;
                            state_d  = StDone;
                        end else begin
                            acc_d    = {{WIDTH{1'b0}}, a_mag};
                            neg_lo_d = a_neg ^ b_neg;
                            // Remainder takes the dividend's sign
                            neg_hi_d = a_neg;
                            state_d  = StDiv;
                        end
                    end else begin
                        opnd_d   = a_mag;
                        acc_d    = {{WIDTH{1'b0}}, b_mag};
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = 1'b0;
                        state_d  = StMul;
                    end
                end
            end
            StMul: begin
                if (annul_i) begin
                    state_d = StIdle;
                end else begin
                    acc_d = mul_next;
                    cnt_d = cnt_dec;
`ifdef EX_MULDIV_EARLY_OUT_EN
                    if (mul_rem_zero) begin
                        acc_d   = mul_aligned;
                        state_d = StDone;
                    end
`else
                    if (cnt_dec == '0) begin
                        state_d = StDone;
                    end
`endif
                end
            end
            StDiv: begin
                if (annul_i) begin
                    state_d = StIdle;
                end else begin
                    acc_d = div_next;
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                res_hi_d = fix_hi;
                res_lo_d = fix_lo;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dbz_q    <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dbz_q    <= dbz_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    // Results are presented during the DONE pulse and held from then on
    always_comb begin
        busy_o        = (state_q != StIdle);
        ready_o       = (state_q == StDone);
        result_hi_o   = ready_o ? fix_hi : res_hi_q;
        result_lo_o   = ready_o ? fix_lo : res_lo_q;
        div_by_zero_o = dbz_q;
    end

endmodule
